// File: rtl/mii_rx_frame_checker.sv
// mii_rx_frame_checker
//   Sits on the MII receive path (phy_rxclk domain). The nibble stream is
//   forwarded unchanged with one register stage. In parallel the block locks
//   onto preamble/SFD, runs CRC-32 over DA..FCS, and checks the body length,
//   the destination address and symbol errors. It then issues a per-frame
//   verdict and keeps saturating good/bad frame counters.
//
// Ports
//   phy_rxclk, reset          clock, asynchronous active-high reset
//   phy_rxd/rxen/rxer         MII receive inputs (low nibble of each byte first)
//   out_rxd/rxen/rxer         the inputs delayed by exactly one cycle, never gated
//   frame_done                1-cycle pulse; frame_ok/crc_err/len_err/sym_err/da_err
//                             are valid on this pulse and hold until the next one
//   good_cnt, bad_cnt         saturating counters of judged frames
//   dbg_state                 current FSM state, for observation only
//
// Handshake: there is no back-pressure. frame_done is a strobe with no ready;
// the consumer must sample the verdict flags on the cycle frame_done is high
// (or any time later, until the next frame_done).
module mii_rx_frame_checker #(
   parameter int unsigned BODY_NIBBLES = 128,
   parameter int unsigned MIN_PRE      = 7,
   parameter logic [47:0] MAC_ADDR     = 48'h0,
   parameter bit          BCAST_EN     = 1'b1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             phy_rxclk,
   input  logic             reset,
   input  logic [3:0]       phy_rxd,
   input  logic             phy_rxen,
   input  logic             phy_rxer,
   output logic [3:0]       out_rxd,
   output logic             out_rxen,
   output logic             out_rxer,
   output logic             frame_done,
   output logic             frame_ok,
   output logic             crc_err,
   output logic             len_err,
   output logic             sym_err,
   output logic             da_err,
   output logic [CNT_W-1:0] good_cnt,
   output logic [CNT_W-1:0] bad_cnt,
   output logic [2:0]       dbg_state
);

   // Body counter is wide enough to count past BODY_NIBBLES; it saturates so a
   // runaway frame can never wrap back to a "correct" length.
   localparam int          BW       = $clog2(BODY_NIBBLES + 13) + 1;
   localparam logic [3:0]  MIN_PRE4 = 4'(MIN_PRE);
   localparam logic [31:0] POLY     = 32'hEDB88320;
   localparam logic [31:0] RESIDUE  = 32'hDEBB20E3;

   typedef enum logic [2:0] {
      S_WAIT = 3'd0,
      S_IDLE = 3'd1,
      S_PRE  = 3'd2,
      S_BODY = 3'd3,
      S_END  = 3'd4,
      S_DROP = 3'd5
   } state_t;

   state_t          state, state_n;
   logic [3:0]      pre_cnt;
   logic [BW-1:0]   body_cnt;
   logic [31:0]     crc;
   logic            da_mac_ok, da_bc_ok, sym_err_r;
   logic [47:0]     mac_shift;
   logic [3:0]      da_exp;
   logic            v_crc, v_len, v_da, v_ok;

   assign dbg_state = state;

   // Reflected CRC-32, one nibble (four bit-steps) per call.
   function automatic logic [31:0] crc_nib(input logic [31:0] c_in, input logic [3:0] d);
      logic [31:0] c;
      c = c_in;
      for (int i = 0; i < 4; i++) begin
         c = {1'b0, c[31:1]} ^ ({32{c[0] ^ d[i]}} & POLY);
      end
      return c;
   endfunction

   always_ff @(posedge phy_rxclk or posedge reset) begin
      if (reset) state <= S_WAIT;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_WAIT: if (!phy_rxen) state_n = S_IDLE;
         S_IDLE: if (phy_rxen && phy_rxd == 4'h5 && !phy_rxer) state_n = S_PRE;
         S_PRE: begin
            if (!phy_rxen)                                 state_n = S_IDLE;
            else if (phy_rxer)                             state_n = S_DROP;
            else if (phy_rxd == 4'h5)                      state_n = S_PRE;
            else if (phy_rxd == 4'hD && pre_cnt >= MIN_PRE4) state_n = S_BODY;
            else                                           state_n = S_DROP;
         end
         S_BODY: if (!phy_rxen) state_n = S_END;
         S_END:  state_n = S_IDLE;
         S_DROP: if (!phy_rxen) state_n = S_IDLE;
         default: state_n = S_WAIT;
      endcase
   end

   // Expected DA nibble for the current body position, and the verdict that
   // is latched while in END.
   always_comb begin
      mac_shift = MAC_ADDR >> {body_cnt[3:0], 2'b00};
      da_exp    = mac_shift[3:0];
      v_crc     = (crc != RESIDUE);
      v_len     = (body_cnt != BW'(BODY_NIBBLES));
      v_da      = (body_cnt < BW'(12)) || !(da_mac_ok || (BCAST_EN && da_bc_ok));
      v_ok      = !(v_crc || v_len || sym_err_r || v_da);
   end

   always_ff @(posedge phy_rxclk or posedge reset) begin
      if (reset) begin
         out_rxd    <= '0;
         out_rxen   <= 1'b0;
         out_rxer   <= 1'b0;
         frame_done <= 1'b0;
         frame_ok   <= 1'b0;
         crc_err    <= 1'b0;
         len_err    <= 1'b0;
         sym_err    <= 1'b0;
         da_err     <= 1'b0;
         good_cnt   <= '0;
         bad_cnt    <= '0;
         pre_cnt    <= '0;
         body_cnt   <= '0;
         crc        <= '1;
         da_mac_ok  <= 1'b0;
         da_bc_ok   <= 1'b0;
         sym_err_r  <= 1'b0;
      end else begin
         out_rxd    <= phy_rxd;
         out_rxen   <= phy_rxen;
         out_rxer   <= phy_rxer;
         frame_done <= 1'b0;
         case (state)
            S_IDLE: if (state_n == S_PRE) pre_cnt <= 4'd1;
            S_PRE: begin
               if (state_n == S_PRE) begin
                  if (pre_cnt != 4'hF) pre_cnt <= pre_cnt + 4'd1;
               end else if (state_n == S_BODY) begin
                  crc       <= '1;
                  body_cnt  <= '0;
                  da_mac_ok <= 1'b1;
                  da_bc_ok  <= 1'b1;
                  sym_err_r <= 1'b0;
               end
            end
            S_BODY: begin
               if (phy_rxen) begin
                  if (body_cnt != '1) body_cnt <= body_cnt + 1'b1;
                  crc <= crc_nib(crc, phy_rxd);
                  if (body_cnt < BW'(12)) begin
                     if (phy_rxd != da_exp) da_mac_ok <= 1'b0;
                     if (phy_rxd != 4'hF)   da_bc_ok  <= 1'b0;
                  end
                  if (phy_rxer) sym_err_r <= 1'b1;
               end
            end
            S_END: begin
               frame_done <= 1'b1;
               frame_ok   <= v_ok;
               crc_err    <= v_crc;
               len_err    <= v_len;
               sym_err    <= sym_err_r;
               da_err     <= v_da;
               if (v_ok) begin
                  if (good_cnt != '1) good_cnt <= good_cnt + 1'b1;
               end else begin
                  if (bad_cnt != '1) bad_cnt <= bad_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mii_rx_frame_checker.sv
// tb_mii_rx_frame_checker
//   Directed frames into two checker instances (16-bit and 2-bit counters).
//   A byte-level frame model predicts each verdict and when it appears; a
//   per-cycle compare process checks pass-through, verdict, flags and counters.
module tb_mii_rx_frame_checker;

   localparam logic [47:0] MAC    = 48'h5E4D3C2B1A09;
   localparam int          BODY_N = 128;
   localparam int          MINP   = 7;
   localparam int          W      = 21;   // {done cycle[15:0], ok, crc, len, sym, da}
   localparam logic [31:0] POLY   = 32'hEDB88320;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] phy_rxd = 4'h0;
   logic       phy_rxen = 1'b0;
   logic       phy_rxer = 1'b0;
   int         cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [3:0]  out_rxd, out_rxd2;
   logic        out_rxen, out_rxer, out_rxen2, out_rxer2;
   logic        frame_done, frame_ok, crc_err, len_err, sym_err, da_err;
   logic        frame_done2, frame_ok2, crc_err2, len_err2, sym_err2, da_err2;
   logic [15:0] good_cnt, bad_cnt;
   logic [1:0]  good_cnt2, bad_cnt2;
   logic [2:0]  dbg_state, dbg_state2;

   mii_rx_frame_checker #(.BODY_NIBBLES(BODY_N), .MIN_PRE(MINP), .MAC_ADDR(MAC),
                          .BCAST_EN(1'b1), .CNT_W(16)) dut (
      .phy_rxclk(clk), .reset(reset), .phy_rxd(phy_rxd), .phy_rxen(phy_rxen),
      .phy_rxer(phy_rxer), .out_rxd(out_rxd), .out_rxen(out_rxen), .out_rxer(out_rxer),
      .frame_done(frame_done), .frame_ok(frame_ok), .crc_err(crc_err), .len_err(len_err),
      .sym_err(sym_err), .da_err(da_err), .good_cnt(good_cnt), .bad_cnt(bad_cnt),
      .dbg_state(dbg_state));

   mii_rx_frame_checker #(.BODY_NIBBLES(BODY_N), .MIN_PRE(MINP), .MAC_ADDR(MAC),
                          .BCAST_EN(1'b1), .CNT_W(2)) dut2 (
      .phy_rxclk(clk), .reset(reset), .phy_rxd(phy_rxd), .phy_rxen(phy_rxen),
      .phy_rxer(phy_rxer), .out_rxd(out_rxd2), .out_rxen(out_rxen2), .out_rxer(out_rxer2),
      .frame_done(frame_done2), .frame_ok(frame_ok2), .crc_err(crc_err2), .len_err(len_err2),
      .sym_err(sym_err2), .da_err(da_err2), .good_cnt(good_cnt2), .bad_cnt(bad_cnt2),
      .dbg_state(dbg_state2));

   // ---------------- checking helpers ----------------
   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- frame model ----------------
   logic [7:0]   frm[$];
   logic [W-1:0] exp_q[$];

   // Byte-wise reflected CRC-32 register over frm[0..n-1] (not inverted).
   function automatic logic [31:0] crc32_q(input int n);
      logic [31:0] c;
      c = '1;
      for (int i = 0; i < n; i++) begin
         c = c ^ {24'h0, frm[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
      end
      return c;
   endfunction

   // ndata bytes (DA first, then random), followed by a correct FCS.
   task automatic build(input logic [47:0] da, input int ndata);
      logic [31:0] fcs;
      frm.delete();
      for (int j = 0; j < ndata; j++)
         frm.push_back(j < 6 ? da[8*j +: 8] : 8'($urandom_range(0, 255)));
      fcs = ~crc32_q(ndata);
      for (int j = 0; j < 4; j++) frm.push_back(fcs[8*j +: 8]);
   endtask

   // {ok, crc_err, len_err, sym_err, da_err} for the frame as sent.
   function automatic logic [4:0] model_verdict(input logic sym);
      int          n;
      logic [31:0] c, fcs;
      logic        ce, le, de, mac_m, bc_m;
      n   = frm.size();
      c   = ~crc32_q(n - 4);
      fcs = {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
      ce  = (c != fcs);
      le  = (2 * n != BODY_N);
      if (2 * n < 12) de = 1'b1;
      else begin
         mac_m = 1'b1;
         bc_m  = 1'b1;
         for (int j = 0; j < 6; j++) begin
            if (frm[j] != MAC[8*j +: 8]) mac_m = 1'b0;
            if (frm[j] != 8'hFF)         bc_m  = 1'b0;
         end
         de = !(mac_m || bc_m);
      end
      return {!(ce || le || sym || de), ce, le, sym, de};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [3:0] d, input logic en, input logic er);
      @(posedge clk);
      #1;
      phy_rxd  = d;
      phy_rxen = en;
      phy_rxer = er;
   endtask

   task automatic send(input int npre, input int er_nib, input int gap);
      int nn;
      nn = 2 * frm.size();
      for (int i = 0; i < npre; i++) drive(4'h5, 1'b1, 1'b0);
      drive(4'hD, 1'b1, 1'b0);
      for (int k = 0; k < nn; k++)
         drive((k % 2) ? frm[k/2][7:4] : frm[k/2][3:0], 1'b1, k == er_nib);
      drive(4'h0, 1'b0, 1'b0);
      // rxen=0 is sampled on the next posedge; the verdict registers one later.
      if (npre >= MINP) exp_q.push_back({16'(cyc + 2), model_verdict(er_nib >= 0)});
      for (int i = 1; i < gap; i++) drive(4'h0, 1'b0, 1'b0);
   endtask

   // Preamble plus part of the body, reset pulsed while rxen stays high.
   task automatic send_reset_mid;
      for (int i = 0; i < 15; i++) drive(4'h5, 1'b1, 1'b0);
      drive(4'hD, 1'b1, 1'b0);
      for (int k = 0; k < 2 * frm.size(); k++) begin
         drive((k % 2) ? frm[k/2][7:4] : frm[k/2][3:0], 1'b1, 1'b0);
         if (k == 30) reset = 1'b1;
         if (k == 32) reset = 1'b0;
      end
      for (int i = 0; i < 12; i++) drive(4'h0, 1'b0, 1'b0);
   endtask

   // ---------------- scoreboard / compare ----------------
   logic [3:0] prev_rxd;
   logic       prev_en, prev_er;
   logic [4:0] m_flags = '0;
   int         m_good = 0, m_bad = 0, m_good2 = 0, m_bad2 = 0;

   always @(posedge clk) begin
      prev_rxd <= reset ? 4'h0 : phy_rxd;
      prev_en  <= reset ? 1'b0 : phy_rxen;
      prev_er  <= reset ? 1'b0 : phy_rxer;
   end

   always @(negedge clk) begin
      logic [W-1:0] e;
      if (reset) begin
         exp_q.delete();
         m_flags = '0;
         m_good = 0; m_bad = 0; m_good2 = 0; m_bad2 = 0;
         chk("reset_outputs", {out_rxd, out_rxen, out_rxer, frame_done, frame_ok,
                               crc_err, len_err, sym_err, da_err}, 32'h0);
         chk("reset_counters", {good_cnt, bad_cnt}, 32'h0);
      end else begin
         chk("pass_through", {out_rxd, out_rxen, out_rxer}, {prev_rxd, prev_en, prev_er});
         if (exp_q.size() != 0 && exp_q[0][20:5] == cyc[15:0]) begin
            e = exp_q.pop_front();
            chk("frame_done", frame_done, 1);
            chk("frame_done_small", frame_done2, 1);
            m_flags = e[4:0];
            if (e[4]) begin
               m_good++;
               if (m_good2 < 3) m_good2++;
            end else begin
               m_bad++;
               if (m_bad2 < 3) m_bad2++;
            end
         end else begin
            chk("frame_done_idle", frame_done, 0);
            chk("frame_done_idle_small", frame_done2, 0);
         end
         chk("verdict_flags", {frame_ok, crc_err, len_err, sym_err, da_err}, m_flags);
         chk("good_cnt", good_cnt, m_good);
         chk("bad_cnt", bad_cnt, m_bad);
         chk("good_cnt_small", good_cnt2, m_good2);
         chk("bad_cnt_small", bad_cnt2, m_bad2);
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      // Pin the model CRC with the standard check value.
      frm.delete();
      for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
      chk("model_crc_pin", ~crc32_q(9), 32'hCBF43926);

      repeat (4) @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 4; i++) drive(4'h0, 1'b0, 1'b0);

      // 1: good 64-byte frame to MAC_ADDR
      build(MAC, 60);
      send(15, -1, 12);
      chk("t1_frame_ok", frame_ok, 1);
      chk("t1_good_cnt", good_cnt, 1);

      // 2: same frame, one payload nibble flipped
      frm[20] = frm[20] ^ 8'h08;
      send(15, -1, 12);
      chk("t2_crc_err", {frame_ok, crc_err}, 2'b01);
      chk("t2_bad_cnt", bad_cnt, 1);

      // 3: original frame, rxer for one body nibble
      frm[20] = frm[20] ^ 8'h08;
      send(15, 50, 12);
      chk("t3_sym_only", {frame_ok, crc_err, len_err, sym_err, da_err}, 5'b00010);
      chk("t3_bad_cnt", bad_cnt, 2);

      // 4: two nibbles short with a correct FCS; then broadcast DA
      build(MAC, 59);
      send(15, -1, 12);
      chk("t4_len_only", {frame_ok, crc_err, len_err, sym_err, da_err}, 5'b00100);
      build(48'hFFFFFFFFFFFF, 60);
      send(15, -1, 12);
      chk("t4_bcast_ok", frame_ok, 1);
      chk("t4_good_cnt", good_cnt, 2);

      // 5: short preambles are dropped; exactly MIN_PRE is accepted
      build(MAC, 60);
      send(4, -1, 12);
      chk("t5_drop_counts", {good_cnt, bad_cnt}, {16'd2, 16'd3});
      send(MINP, -1, 12);
      chk("t5_min_pre_good", good_cnt, 3);
      send(MINP - 1, -1, 12);
      chk("t5_drop6_counts", {good_cnt, bad_cnt}, {16'd3, 16'd3});

      // tiny frame (10 body nibbles): da_err and len_err, CRC good
      build(MAC, 1);
      send(15, -1, 12);
      chk("t5_tiny_flags", {frame_ok, crc_err, len_err, sym_err, da_err}, 5'b00101);

      // foreign DA
      build(48'h112233445566, 60);
      send(15, -1, 12);
      chk("t5_da_err", {frame_ok, da_err}, 2'b01);

      // two frames separated by a single idle cycle
      build(MAC, 60);
      send(15, -1, 1);
      send(15, -1, 12);
      chk("t5_pair_counts", {good_cnt, bad_cnt}, {16'd5, 16'd5});
      chk("t5_small_sat", {good_cnt2, bad_cnt2}, 4'b1111);

      // reset in mid-body: no verdict, then a clean frame is judged ok
      send_reset_mid();
      chk("t5_after_reset", {good_cnt, bad_cnt}, 32'h0);
      send(15, -1, 12);
      chk("t5_post_reset_ok", {frame_ok, good_cnt}, {1'b1, 16'd1});

      // 6: counter saturation on the 2-bit instance
      for (int i = 0; i < 3; i++) send(15, -1, 12);
      chk("t6_good_cnt", good_cnt, 4);
      chk("t6_small_good_sat", good_cnt2, 2'b11);

      for (int i = 0; i < 8; i++) drive(4'h0, 1'b0, 1'b0);
      chk("no_pending_verdict", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
